// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional two's complement mode is enabled with the SIGNED_DIV_EN macro.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_step, q_step;
  logic [WIDTH-1:0] quot_fix, rem_fix;

`ifdef SIGNED_DIV_EN
  logic qneg_q, qneg_d;
  logic dneg_q, dneg_d;

  // Operand magnitudes and final sign fix-up for two's complement mode
  always_comb begin
    a_mag    = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag    = divisor[WIDTH-1] ? -divisor : divisor;
    quot_fix = qneg_q ? -q_step : q_step;
    rem_fix  = dneg_q ? -rem_step : rem_step;
  end
`else
  // Unsigned mode: operands and results pass straight through
  always_comb begin
    a_mag    = dividend;
    b_mag    = divisor;
    quot_fix = q_step;
    rem_fix  = rem_step;
  end
`endif

  // One restoring step: shift in next dividend bit, trial subtract, keep or restore
  always_comb begin
    shifted  = {rem_q, q_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_step   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    qneg_d  = qneg_q;
    dneg_d  = dneg_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          if (divisor == '0) begin
            zero_d = 1'b1;
            q_d    = dividend;
            cnt_d  = '0;
          end else begin
            zero_d = 1'b0;
            rem_d  = '0;
            q_d    = a_mag;
            dvsr_d = b_mag;
            cnt_d  = CW'(WIDTH);
          end
`ifdef SIGNED_DIV_EN
          qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          dneg_d = dividend[WIDTH-1];
`endif
        end
      end
      RUN: begin
        if (zero_q) begin
          state_d = DONE;
          quot_d  = '1;
          remd_d  = q_q;
          dbz_d   = 1'b1;
        end else begin
          rem_d = rem_step;
          q_d   = q_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            quot_d  = quot_fix;
            remd_d  = rem_fix;
            dbz_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      dneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      qneg_q  <= qneg_d;
      dneg_q  <= dneg_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Testbench for seq_restoring_divider: directed and random divisions
// checked against an arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] pq, pr;
  logic         pz;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] eq,
                                output logic [W-1:0] er,
                                output logic ez);
    ez = (b == 0);
    if (ez) begin
      eq = '1;
      er = a;
    end else begin
`ifdef SIGNED_DIV_EN
      int sa, sb, qi, ri;
      sa = $signed(a);
      sb = $signed(b);
      qi = sa / sb;
      ri = sa % sb;
      eq = qi[W-1:0];
      er = ri[W-1:0];
`else
      eq = a / b;
      er = a % b;
`endif
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a start for one edge, then scramble the operand inputs
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Wait (bounded) for done and compare result and latency with the model
  task automatic expect_result(input string tag,
                               input logic [W-1:0] a,
                               input logic [W-1:0] b,
                               input int already);
    logic [W-1:0] eq, er;
    logic ez;
    int n;
    model(a, b, eq, er, ez);
    n = already;
    while (done !== 1'b1 && n < 4 * W) begin
      tick();
      n++;
    end
    check({tag, ".lat"}, n, ez ? 1 : W);
    check({tag, ".busy_lo"}, busy, 1'b0);
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    check({tag, ".dbz"}, div_by_zero, ez);
    pq = eq;
    pr = er;
    pz = ez;
  endtask

  task automatic run(input string tag,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b);
    launch(a, b);
    check({tag, ".busy"}, busy, 1'b1);
    check({tag, ".hold_q"}, quotient, pq);
    check({tag, ".hold_r"}, remainder, pr);
    check({tag, ".hold_z"}, div_by_zero, pz);
    expect_result(tag, a, b, 0);
  endtask

  task automatic idle_check(input string tag);
    tick();
    check({tag, ".done_lo"}, done, 1'b0);
    check({tag, ".idle_busy"}, busy, 1'b0);
    check({tag, ".idle_q"}, quotient, pq);
  endtask

  initial begin
    int hits;
    logic [W-1:0] ra, rb;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    pq = '0;
    pr = '0;
    pz = 1'b0;
    tick();
    tick();
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.q", quotient, '0);
    check("rst.r", remainder, '0);
    check("rst.dbz", div_by_zero, 1'b0);
    reset = 1'b0;
    tick();

    run("d13_3", 4'd13, 4'd3);
`ifndef SIGNED_DIV_EN
    check("d13_3.q4", quotient, 4'd4);
    check("d13_3.r1", remainder, 4'd1);
`endif
    idle_check("d13_3");

    run("d7_0", 4'd7, 4'd0);
    check("d7_0.qF", quotient, 4'hF);
    check("d7_0.r7", remainder, 4'd7);
    idle_check("d7_0");
    run("d15_15", 4'hF, 4'hF);

    launch(4'd9, 4'd2);
    check("ign.busy", busy, 1'b1);
    tick();
    start    = 1'b1;
    dividend = 4'd15;
    divisor  = 4'd1;
    tick();
    start    = 1'b0;
    check("ign.busy2", busy, 1'b1);
    expect_result("ign", 4'd9, 4'd2, 2);
    idle_check("ign");

    launch(4'd14, 4'd3);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mrst.busy", busy, 1'b0);
    check("mrst.done", done, 1'b0);
    check("mrst.q", quotient, '0);
    check("mrst.r", remainder, '0);
    check("mrst.dbz", div_by_zero, 1'b0);
    tick();
    reset = 1'b0;
    pq = '0;
    pr = '0;
    pz = 1'b0;
    hits = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done === 1'b1) hits++;
    end
    check("mrst.nodone", hits, 0);
    run("d14_3", 4'd14, 4'd3);

    run("b2b1", 4'd10, 4'd4);
    run("b2b2", 4'd5, 4'd5);
    idle_check("b2b");

    run("z_div", 4'd0, 4'd5);
    run("big_dvsr", 4'd3, 4'd7);
    run("by_one", 4'd11, 4'd1);
    idle_check("bnd");

`ifdef SIGNED_DIV_EN
    run("s_m7_2", 4'h9, 4'h2);
    check("s_m7_2.qD", quotient, 4'hD);
    check("s_m7_2.rF", remainder, 4'hF);
    run("s_m8_m1", 4'h8, 4'hF);
    check("s_m8_m1.q8", quotient, 4'h8);
    check("s_m8_m1.r0", remainder, 4'h0);
    run("s_7_m2", 4'h7, 4'hE);
    check("s_7_m2.qD", quotient, 4'hD);
    check("s_7_m2.r1", remainder, 4'h1);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run("rnd", ra, rb);
      if ($urandom_range(0, 2) == 0) idle_check("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Sequential unsigned restoring divider. It is the inverse of the team's combinational array multiplier: it produces quotient and remainder from a dividend and divisor, one quotient bit per clock.
Sits beside the multiplier in the mult/div datapath and is driven by a start/busy/done handshake.
Uses an internal subtract/compare per iteration; no combinational divide operator.

Parameters:
WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder (must be >= 2)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  request a division; sampled on the rising edge
dividend  input  WIDTH  numerator; captured only on an accepted start
divisor  input  WIDTH  denominator; captured only on an accepted start
busy  output  1  high while a division is in progress
done  output  1  single-cycle pulse when results become valid
quotient  output  WIDTH  result quotient; held until the next accepted start
remainder  output  WIDTH  result remainder; held until the next accepted start
div_by_zero  output  1  set with done when the captured divisor was 0; held with the results

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset (including mid-operation):
  - state goes to IDLE, iteration counter cleared
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0
  - any in-flight division is abandoned with no done pulse
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted when busy=0, i.e. in IDLE or DONE.
  - start while busy=1 is ignored and does not disturb the running division.
- Accepted start at edge k, divisor != 0:
  - load rem=0 (WIDTH+1 bits) and q=dividend
  - counter=WIDTH, state RUN, busy=1, done=0, div_by_zero=0
- RUN iteration, one per edge:
  - trial = {rem[WIDTH-1:0], q[WIDTH-1]} - {1'b0, divisor}, computed WIDTH+1 bits wide
  - if trial is non-negative (MSB=0): rem=trial, shift 1 into q LSB
  - otherwise: rem={rem[WIDTH-1:0], q[WIDTH-1]}, shift 0 into q LSB
  - counter decrements each iteration
- Completion:
  - the last iteration occurs at edge k+WIDTH
  - at that same edge: state DONE, busy=0, done=1, quotient=q, remainder=rem[WIDTH-1:0]
  - latency from start edge to done is WIDTH cycles
- Divide by zero (divisor==0 at accepted start edge k):
  - skip RUN
  - at edge k+1: state DONE, done=1, quotient=all ones, remainder=dividend, div_by_zero=1
  - busy is high only for the cycle between edge k and edge k+1
- DONE state:
  - lasts one cycle
  - next edge goes to IDLE with done=0
  - if start is high on that edge, it goes directly to the new division (RUN or the zero path) instead
- Outputs during RUN: quotient, remainder and div_by_zero hold the previous result until completion; they are never partial values.
- Input stability: dividend and divisor changes after the accepted start have no effect.
- Boundary cases:
  - dividend=0 gives quotient 0, remainder 0
  - divisor > dividend gives quotient 0, remainder=dividend
  - divisor=1 gives quotient=dividend, remainder 0
  - all ones / all ones gives quotient 1, remainder 0

Optional Feature:
Macro: SIGNED_DIV_EN
- Defined:
  - dividend, divisor, quotient and remainder are two's complement
  - on start, magnitudes are loaded and the sign of the quotient (XOR of operand signs) and the sign of the dividend are registered
  - on completion, the quotient is negated if its sign is set and the remainder is negated if the dividend was negative
  - result is truncation toward zero; remainder takes the dividend's sign
  - most-negative / -1 gives quotient=most-negative (wraps), remainder 0
  - divide by zero gives quotient all ones (-1), remainder=dividend
  - latency is unchanged; sign fix-up is applied in the completing edge
- Undefined: unsigned operation exactly as in Behaviour; no sign logic is synthesised.

Test Plan:
- WIDTH=4, start at edge k with dividend=13, divisor=3 -> busy high from k, done pulse at edge k+4, quotient=4, remainder=1, div_by_zero=0.
- dividend=7, divisor=0 -> done at edge k+1, quotient=4'hF, remainder=7, div_by_zero=1; next division 15/15 -> quotient=1, remainder=0, div_by_zero=0.
- Start 9/2, then a second start with 15/1 pulsed at edge k+2 while busy -> ignored; done at k+4 with quotient=4, remainder=1.
- Start 14/3, assert reset at edge k+2 -> busy, done, quotient and remainder 0 immediately; no done pulse; a subsequent 14/3 gives quotient=4, remainder=2.
- Back-to-back: 10/4 done at k+4 with start high on that DONE cycle for 5/5 -> first result quotient=2, remainder=2; second done at k+9 with quotient=1, remainder=0.
- SIGNED_DIV_EN: -7/2 -> quotient=4'hD (-3), remainder=4'hF (-1); -8/-1 -> quotient=4'h8, remainder=0; 7/-2 -> quotient=4'hD, remainder=1.
